// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the memory stage.
// Holds the memory opcodes, the LSU FSM state encoding, the memory-op enum
// and a decoder that maps an opcode onto (access kind, store flag).
package mips_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } lsu_state_e;

  typedef enum logic [2:0] {
    MOP_NONE  = 3'd0,
    MOP_WORD  = 3'd1,
    MOP_HALF  = 3'd2,
    MOP_HALFU = 3'd3,
    MOP_BYTE  = 3'd4,
    MOP_BYTEU = 3'd5
  } mem_op_e;

  typedef struct packed {
    mem_op_e op;
    logic    store;
  } mem_dec_t;

  // Stores reuse the signed access kinds; only their width matters.
  function automatic mem_dec_t decode_mem(input logic [5:0] opcode);
    mem_dec_t d;
    d = '{op: MOP_NONE, store: 1'b0};
    case (opcode)
      OP_LW:   d.op = MOP_WORD;
      OP_LH:   d.op = MOP_HALF;
      OP_LHU:  d.op = MOP_HALFU;
      OP_LB:   d.op = MOP_BYTE;
      OP_LBU:  d.op = MOP_BYTEU;
      OP_SW:   d = '{op: MOP_WORD, store: 1'b1};
      OP_SH:   d = '{op: MOP_HALF, store: 1'b1};
      OP_SB:   d = '{op: MOP_BYTE, store: 1'b1};
      default: d = '{op: MOP_NONE, store: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load lane select and sign/zero extension.
// Ports:
//   word   in  32  aligned memory word
//   lane   in  2   byte offset (AO[1:0])
//   op     in  3   load kind; MOP_NONE yields zero
//   result out 32  extended load value
// Purely combinational so that bypass logic can reuse it.
module mem_load_ext
  import mips_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  mem_op_e     op,
  output logic [31:0] result
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign half_sel = lane[1] ? word[31:16] : word[15:0];
  assign byte_sel = word[{lane, 3'b000} +: 8];

  // NOTE: every path assigns result (default first), so no latch is inferred.
  always_comb begin
    result = '0;
    case (op)
      MOP_WORD:  result = word;
      MOP_HALF:  result = {{16{half_sel[15]}}, half_sel};
      MOP_HALFU: result = {16'h0000, half_sel};
      MOP_BYTE:  result = {{24{byte_sel[7]}}, byte_sel};
      MOP_BYTEU: result = {24'h000000, byte_sel};
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit.
// Drives the data-memory bus (req/gnt/rvalid handshake) for the instruction
// held in EX/MEM, stalls the upstream pipeline while an access is in flight,
// and registers the MEM/WB fields including the extended load data.
// Ports:
//   clk, reset                      clock, async active-low reset
//   M_Instr/M_PC/M_AO/M_V2/M_A3     EX/MEM fields (AO = effective address)
//   stall                           freeze PC, F/D, D/E, EX/MEM
//   dm_req/we/addr/be/wdata         bus request side
//   dm_gnt/rvalid/rdata             bus response side
//   W_Instr/W_PC/W_AO/W_DR/W_A3     MEM/WB fields (W_DR = load data)
//   W_addr_err                      misaligned access flag
module mem_stage_lsu
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_Instr,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_AO,
  input  logic [31:0] M_V2,
  input  logic [4:0]  M_A3,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic [31:0] W_Instr,
  output logic [31:0] W_PC,
  output logic [31:0] W_AO,
  output logic [31:0] W_DR,
  output logic [4:0]  W_A3,
  output logic        W_addr_err
);

  mem_dec_t   dec;
  logic       is_mem;
  logic       misaligned;
  logic       aligned_mem;
  lsu_state_e state_q, state_d;
  logic       req_int;
  logic       capture;
  logic       stall_int;
  logic [3:0] be_int;
  logic [31:0] wdata_int;
  logic [31:0] rbuf_q;
  logic [31:0] ext_result;
  mem_op_e    load_op;

  assign dec    = decode_mem(M_Instr[31:26]);
  assign is_mem = (dec.op != MOP_NONE);

  assign misaligned = ((dec.op == MOP_WORD) && (M_AO[1:0] != 2'b00)) ||
                      (((dec.op == MOP_HALF) || (dec.op == MOP_HALFU)) && M_AO[0]);
  assign aligned_mem = is_mem && !misaligned;

  // The grant ends the request phase; stores have nothing to wait for.
  always_comb begin
    state_d = state_q;
    req_int = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (aligned_mem) begin
          req_int = 1'b1;
          if (dm_gnt) state_d = dec.store ? ST_DONE : ST_WAIT_R;
          else        state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        req_int = 1'b1;
        if (dm_gnt) state_d = dec.store ? ST_DONE : ST_WAIT_R;
      end
      ST_WAIT_R: begin
        if (dm_rvalid) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments with the async
  // reset in the sensitivity list, so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       rbuf_q <= '0;
    else if (capture) rbuf_q <= dm_rdata;
  end

  assign stall_int = aligned_mem && (state_q != ST_DONE);

  // Store lane steering; loads keep all byte enables on.
  always_comb begin
    be_int    = 4'b1111;
    wdata_int = M_V2;
    if (dec.store) begin
      case (dec.op)
        MOP_HALF: begin
          be_int    = M_AO[1] ? 4'b1100 : 4'b0011;
          wdata_int = {2{M_V2[15:0]}};
        end
        MOP_BYTE: begin
          be_int    = 4'b0001 << M_AO[1:0];
          wdata_int = {4{M_V2[7:0]}};
        end
        default: begin
          be_int    = 4'b1111;
          wdata_int = M_V2;
        end
      endcase
    end
  end

  // Reset also masks the bus and stall combinationally so that an access
  // in flight is dropped immediately, not at the next edge.
  assign stall    = reset && stall_int;
  assign dm_req   = reset && req_int;
  assign dm_we    = reset && aligned_mem && dec.store;
  assign dm_addr  = reset ? {M_AO[31:2], 2'b00} : 32'h0;
  assign dm_be    = reset ? be_int : 4'b0000;
  assign dm_wdata = reset ? wdata_int : 32'h0;

  assign load_op = dec.store ? MOP_NONE : dec.op;

  mem_load_ext u_ext (
    .word   (rbuf_q),
    .lane   (M_AO[1:0]),
    .op     (load_op),
    .result (ext_result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      W_Instr    <= '0;
      W_PC       <= '0;
      W_AO       <= '0;
      W_DR       <= '0;
      W_A3       <= '0;
      W_addr_err <= 1'b0;
    end else if (!stall_int) begin
      // A misaligned op retires as a bubble carrying the error flag.
      W_Instr    <= misaligned ? 32'h0 : M_Instr;
      W_PC       <= M_PC;
      W_AO       <= M_AO;
      W_DR       <= (state_q == ST_DONE) ? ext_result : 32'h0;
      W_A3       <= misaligned ? 5'd0 : M_A3;
      W_addr_err <= misaligned;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: the stimulus pushes expected MEM/WB
// values, a monitor pops them whenever the W registers update.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] M_Instr, M_PC, M_AO, M_V2;
  logic [4:0]  M_A3;
  logic        stall, dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic [31:0] W_Instr, W_PC, W_AO, W_DR;
  logic [4:0]  W_A3;
  logic        W_addr_err;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .reset(reset),
    .M_Instr(M_Instr), .M_PC(M_PC), .M_AO(M_AO), .M_V2(M_V2), .M_A3(M_A3),
    .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .W_Instr(W_Instr), .W_PC(W_PC), .W_AO(W_AO), .W_DR(W_DR),
    .W_A3(W_A3), .W_addr_err(W_addr_err)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] ao;
    logic [31:0] dr;
    logic [4:0]  a3;
    logic        err;
  } wexp_t;

  wexp_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd4, rt, 16'h0010};
  endfunction

  task automatic set_m(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] ao, input logic [31:0] v2, input logic [4:0] a3);
    M_Instr = instr; M_PC = pc; M_AO = ao; M_V2 = v2; M_A3 = a3;
  endtask

  task automatic expect_w(input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] ao, input logic [31:0] dr,
                          input logic [4:0] a3, input logic err);
    wexp_t e;
    e.instr = instr; e.pc = pc; e.ao = ao; e.dr = dr; e.a3 = a3; e.err = err;
    sb_q.push_back(e);
  endtask

  // Monitor: a W update happens at every edge where reset=1 and stall=0.
  initial begin
    logic  upd;
    wexp_t e;
    forever begin
      @(negedge clk); #1;
      upd = reset && !stall;
      @(posedge clk); #1;
      if (upd) begin
        if (sb_q.size() == 0) begin
          check("w_update_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("W_Instr", W_Instr, e.instr);
          check("W_PC", W_PC, e.pc);
          check("W_AO", W_AO, e.ao);
          check("W_DR", W_DR, e.dr);
          check("W_A3", 32'(W_A3), 32'(e.a3));
          check("W_addr_err", 32'(W_addr_err), 32'(e.err));
        end
      end
    end
  end

  // Drives gnt/rvalid with the requested delays (cycles from the first
  // request cycle; rvalid counted from the cycle after gnt) and checks the
  // bus and the number of stall cycles. Returns in the DONE/free cycle.
  task automatic run_access(input int gnt_delay, input int rv_delay,
                            input logic [31:0] rdata, input logic exp_we,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input int exp_stalls,
                            input string tag);
    int cyc = 0;
    int gnt_cyc = -1;
    int stalls = 0;
    bit granted = 0;
    forever begin
      dm_gnt    = !granted && (cyc == gnt_delay);
      dm_rvalid = granted && !exp_we && (cyc == gnt_cyc + 1 + rv_delay);
      dm_rdata  = dm_rvalid ? rdata : 32'hBAD0BAD0;
      #1;
      if (!stall) break;
      stalls++;
      check({tag, "_req"}, 32'(dm_req), 32'(!granted));
      if (dm_req) begin
        check({tag, "_addr"}, dm_addr, exp_addr);
        check({tag, "_we"}, 32'(dm_we), 32'(exp_we));
        check({tag, "_be"}, 32'(dm_be), 32'(exp_be));
        if (exp_we) check({tag, "_wdata"}, dm_wdata, exp_wdata);
        if (dm_gnt) begin
          granted = 1;
          gnt_cyc = cyc;
        end
      end
      if (cyc > 40) begin
        check({tag, "_timeout"}, 32'd1, 32'd0);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_req_done"}, 32'(dm_req), 32'd0);
    dm_gnt = 1'b0;
    dm_rvalid = 1'b0;
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
  endtask

  logic [31:0] i_addu, i_addu2, i;

  initial begin
    i_addu  = 32'h00851021;
    i_addu2 = 32'h00A63021;
    reset = 1'b0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
    set_m(mk(6'b101011, 5'd0), 32'h100, 32'h10, 32'hDEADBEEF, 5'd2);

    // Reset state: bus and stall forced low even with a store presented.
    repeat (2) @(negedge clk);
    #1;
    check("rst_dm_req", 32'(dm_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_dm_be", 32'(dm_be), 32'd0);
    check("rst_dm_we", 32'(dm_we), 32'd0);
    check("rst_W_Instr", W_Instr, 32'h0);
    check("rst_W_AO", W_AO, 32'h0);
    check("rst_W_addr_err", 32'(W_addr_err), 32'd0);

    // addu: single cycle, no stall.
    @(negedge clk);
    reset = 1'b1;
    set_m(i_addu, 32'h1000, 32'h1234, 32'h5555, 5'd2);
    expect_w(i_addu, 32'h1000, 32'h1234, 32'h0, 5'd2, 1'b0);
    #1;
    check("addu_stall", 32'(stall), 32'd0);
    check("addu_req", 32'(dm_req), 32'd0);

    // sw, immediate grant.
    @(negedge clk);
    i = mk(6'b101011, 5'd3);
    set_m(i, 32'h1004, 32'h10, 32'hDEADBEEF, 5'd3);
    expect_w(i, 32'h1004, 32'h10, 32'h0, 5'd3, 1'b0);
    run_access(0, 0, 32'h0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 1, "sw");

    // lb AO=0x13, gnt after 2 cycles, rvalid right after gnt.
    @(negedge clk);
    i = mk(6'b100000, 5'd8);
    set_m(i, 32'h1008, 32'h13, 32'h0, 5'd8);
    expect_w(i, 32'h1008, 32'h13, 32'hFFFFFF80, 5'd8, 1'b0);
    run_access(2, 0, 32'h80FF0000, 1'b0, 32'h10, 4'b1111, 32'h0, 4, "lb");

    // lhu AO=0x22 upper half, zero extended.
    @(negedge clk);
    i = mk(6'b100101, 5'd9);
    set_m(i, 32'h100C, 32'h22, 32'h0, 5'd9);
    expect_w(i, 32'h100C, 32'h22, 32'h00008001, 5'd9, 1'b0);
    run_access(0, 0, 32'h80017FFF, 1'b0, 32'h20, 4'b1111, 32'h0, 2, "lhu");

    // sb AO=0x21 back-to-back.
    @(negedge clk);
    i = mk(6'b101000, 5'd0);
    set_m(i, 32'h1010, 32'h21, 32'h000000AB, 5'd0);
    expect_w(i, 32'h1010, 32'h21, 32'h0, 5'd0, 1'b0);
    run_access(0, 0, 32'h0, 1'b1, 32'h20, 4'b0010, 32'hABABABAB, 1, "sb");

    // lw AO=0x06 misaligned.
    @(negedge clk);
    i = mk(6'b100011, 5'd10);
    set_m(i, 32'h1014, 32'h06, 32'h0, 5'd10);
    expect_w(32'h0, 32'h1014, 32'h06, 32'h0, 5'd0, 1'b1);
    #1;
    check("lw_mis_req", 32'(dm_req), 32'd0);
    check("lw_mis_stall", 32'(stall), 32'd0);

    // lh AO=0x20 lower half sign-extended, rvalid 2 cycles late.
    @(negedge clk);
    i = mk(6'b100001, 5'd11);
    set_m(i, 32'h1018, 32'h20, 32'h0, 5'd11);
    expect_w(i, 32'h1018, 32'h20, 32'hFFFF8765, 5'd11, 1'b0);
    run_access(0, 2, 32'h12348765, 1'b0, 32'h20, 4'b1111, 32'h0, 4, "lh");

    // sh AO=0x02, gnt one cycle late (request held stable).
    @(negedge clk);
    i = mk(6'b101001, 5'd0);
    set_m(i, 32'h101C, 32'h02, 32'h1234CAFE, 5'd0);
    expect_w(i, 32'h101C, 32'h02, 32'h0, 5'd0, 1'b0);
    run_access(1, 0, 32'h0, 1'b1, 32'h0, 4'b1100, 32'hCAFECAFE, 2, "sh");

    // lh AO=0x23 misaligned.
    @(negedge clk);
    i = mk(6'b100001, 5'd12);
    set_m(i, 32'h1020, 32'h23, 32'h0, 5'd12);
    expect_w(32'h0, 32'h1020, 32'h23, 32'h0, 5'd0, 1'b1);
    #1;
    check("lh_mis_req", 32'(dm_req), 32'd0);

    // lbu AO=0x13 zero extended.
    @(negedge clk);
    i = mk(6'b100100, 5'd13);
    set_m(i, 32'h1024, 32'h13, 32'h0, 5'd13);
    expect_w(i, 32'h1024, 32'h13, 32'h00000080, 5'd13, 1'b0);
    run_access(0, 0, 32'h80FF0000, 1'b0, 32'h10, 4'b1111, 32'h0, 2, "lbu");

    // lw AO=0x30, rvalid one cycle late.
    @(negedge clk);
    i = mk(6'b100011, 5'd14);
    set_m(i, 32'h1028, 32'h30, 32'h0, 5'd14);
    expect_w(i, 32'h1028, 32'h30, 32'hCAFEF00D, 5'd14, 1'b0);
    run_access(0, 1, 32'hCAFEF00D, 1'b0, 32'h30, 4'b1111, 32'h0, 3, "lw");

    // Reset while waiting for read data: the access is abandoned.
    @(negedge clk);
    set_m(mk(6'b100011, 5'd15), 32'h1030, 32'h40, 32'h0, 5'd15);
    dm_gnt = 1'b1;
    #1;
    check("abort_req", 32'(dm_req), 32'd1);
    @(posedge clk); #1;
    dm_gnt = 1'b0;
    check("abort_wait_stall", 32'(stall), 32'd1);
    check("abort_wait_req", 32'(dm_req), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_rst_req", 32'(dm_req), 32'd0);
    check("abort_rst_stall", 32'(stall), 32'd0);
    check("abort_rst_W_Instr", W_Instr, 32'h0);
    check("abort_rst_W_PC", W_PC, 32'h0);
    check("abort_rst_W_DR", W_DR, 32'h0);
    check("abort_rst_W_A3", 32'(W_A3), 32'd0);

    @(negedge clk);
    set_m(i_addu2, 32'h1034, 32'h77, 32'h0, 5'd16);
    @(negedge clk);
    reset = 1'b1;
    dm_rvalid = 1'b1;
    dm_rdata = 32'hFFFFFFFF;
    expect_w(i_addu2, 32'h1034, 32'h77, 32'h0, 5'd16, 1'b0);
    #1;
    check("late_rvalid_stall", 32'(stall), 32'd0);
    check("late_rvalid_req", 32'(dm_req), 32'd0);

    // FSM restarted cleanly: a normal load behaves as usual.
    @(negedge clk);
    dm_rvalid = 1'b0;
    i = mk(6'b100011, 5'd17);
    set_m(i, 32'h1038, 32'h44, 32'h0, 5'd17);
    expect_w(i, 32'h1038, 32'h44, 32'h11223344, 5'd17, 1'b0);
    run_access(0, 0, 32'h11223344, 1'b0, 32'h44, 4'b1111, 32'h0, 2, "lw_after_rst");

    // Hold reset so idle cycles produce no further W updates.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
